cd_host_link: RTL and testbench

- Host-side master of the 4-bit CDD serial bus; the counterpart of the CD drive MCU model.
- On each drive IRQ it clocks in a 10-nibble status frame (drive-to-host), then clocks out a 10-nibble command frame (host-to-drive) using the HOCK/CDCK handshake.
- It sits between the CD subsystem's register file and the CDD bus pins.
- It generates the command checksum, checks the status checksum, and aborts on handshake timeouts.

---
 rtl/cd_host_link.sv | 249 ++++++++++++++++++++++++
 tb/tb_cd_host_link.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_host_link.sv
// Host-side master of the 4-bit CDD serial bus: per drive IRQ, reads a 10-nibble status
// frame and then writes a 10-nibble command frame over the HOCK/CDCK handshake.
//
// state | meaning
// IDLE  | HOCK high, waiting for a fresh nIRQ falling edge
// S_LO  | status nibble requested (HOCK low), waiting for CDCK low
// S_HI  | status nibble taken (HOCK high), waiting for CDCK high
// C_LO  | command nibble on CDD_DIN, waiting for CDCK low, then setup time
// C_HI  | command nibble presented (HOCK high), waiting for CDCK high
// DONE  | report completion and status checksum result
module cd_host_link #(
   parameter int SETUP_CYC   = 16,
   parameter int TIMEOUT_CYC = 65535,
   parameter bit GEN_CKSUM   = 1'b1
) (
   input  logic        clk_sys,
   input  logic        nRESET,
   input  logic        CDD_nIRQ,
   input  logic        CDCK,
   input  logic [3:0]  CDD_DOUT,
   output logic        HOCK,
   output logic [3:0]  CDD_DIN,
   input  logic [39:0] CMD_IN,
   input  logic        CMD_LOAD,
   output logic [39:0] STATUS_OUT,
   output logic        STATUS_VALID,
   output logic        CMD_DONE,
   output logic        CKSUM_ERR,
   output logic        TIMEOUT_ERR,
   output logic        BUSY
);

   localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam int SW = (SETUP_CYC < 2) ? 1 : $clog2(SETUP_CYC + 1);
   localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC - 1);
   localparam logic [SW-1:0] SU_LOAD = SW'(SETUP_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_S_LO, ST_S_HI, ST_C_LO, ST_C_HI, ST_DONE
   } state_t;

   state_t        state_q;
   logic          nirq_s1_q, nirq_s2_q, nirq_d_q;
   logic          cdck_s1_q, cdck_s2_q;
   logic [3:0]    dout_s1_q, dout_s2_q;
   logic          hock_q;
   logic [3:0]    din_q;
   logic [39:0]   status_q, pend_q, shadow_q, tx_q, rx_q;
   logic          shadow_vld_q, setup_act_q;
   logic [3:0]    idx_q;
   logic [TW-1:0] wait_q;
   logic [SW-1:0] setup_q;
   logic          sv_q, done_q, ckerr_q, toerr_q;
   logic          nirq_fall, stall, abort;

   function automatic logic [3:0] cksum(input logic [39:0] f);
      logic [3:0] s;
      s = 4'd0;
      for (int k = 0; k < 9; k++) s = s + f[4*k +: 4];
      return ~s;
   endfunction

   function automatic logic [39:0] frame_tx(input logic [39:0] c);
      logic [39:0] f;
      f = c;
      if (GEN_CKSUM) f[39:36] = cksum(c);
      return f;
   endfunction

   function automatic logic [3:0] nib(input logic [39:0] v, input logic [3:0] k);
      return v[4*k +: 4];
   endfunction

   always_ff @(posedge clk_sys) begin
      if (!nRESET) begin
         nirq_s1_q <= 1'b1;
         nirq_s2_q <= 1'b1;
         nirq_d_q  <= 1'b1;
         cdck_s1_q <= 1'b1;
         cdck_s2_q <= 1'b1;
         dout_s1_q <= 4'd0;
         dout_s2_q <= 4'd0;
      end else begin
         nirq_s1_q <= CDD_nIRQ;
         nirq_s2_q <= nirq_s1_q;
         nirq_d_q  <= nirq_s2_q;
         cdck_s1_q <= CDCK;
         cdck_s2_q <= cdck_s1_q;
         dout_s1_q <= CDD_DOUT;
         dout_s2_q <= dout_s1_q;
      end
   end

   // The edge detector runs in every state, so edges seen while busy are consumed.
   assign nirq_fall = nirq_d_q & ~nirq_s2_q;

   always_comb begin
      stall = 1'b0;
      case (state_q)
         ST_S_LO: stall = cdck_s2_q;
         ST_S_HI: stall = ~cdck_s2_q;
         ST_C_LO: stall = ~setup_act_q & cdck_s2_q;
         ST_C_HI: stall = ~cdck_s2_q;
         default: stall = 1'b0;
      endcase
   end

   assign abort = stall && (wait_q == '0);

   always_ff @(posedge clk_sys) begin
      if (!nRESET) begin
         state_q      <= ST_IDLE;
         hock_q       <= 1'b1;
         din_q        <= 4'd0;
         status_q     <= 40'd0;
         pend_q       <= 40'd0;
         shadow_q     <= 40'd0;
         shadow_vld_q <= 1'b0;
         tx_q         <= 40'd0;
         rx_q         <= 40'd0;
         idx_q        <= 4'd0;
         wait_q       <= '0;
         setup_q      <= '0;
         setup_act_q  <= 1'b0;
         sv_q         <= 1'b0;
         done_q       <= 1'b0;
         ckerr_q      <= 1'b0;
         toerr_q      <= 1'b0;
      end else begin
         sv_q    <= 1'b0;
         done_q  <= 1'b0;
         ckerr_q <= 1'b0;
         toerr_q <= 1'b0;
         if (CMD_LOAD && state_q != ST_IDLE) begin
            shadow_q     <= CMD_IN;
            shadow_vld_q <= 1'b1;
         end
         if (abort) begin
            // Aborted command goes back to pending unless the host has queued a newer one.
            hock_q       <= 1'b1;
            toerr_q      <= 1'b1;
            idx_q        <= 4'd0;
            setup_act_q  <= 1'b0;
            wait_q       <= '0;
            shadow_vld_q <= 1'b0;
            state_q      <= ST_IDLE;
            if (CMD_LOAD)          pend_q <= CMD_IN;
            else if (shadow_vld_q) pend_q <= shadow_q;
            else                   pend_q <= tx_q;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (nirq_fall) begin
                     tx_q    <= frame_tx(pend_q);
                     pend_q  <= 40'd0;
                     hock_q  <= 1'b0;
                     idx_q   <= 4'd0;
                     wait_q  <= TO_LOAD;
                     state_q <= ST_S_LO;
                  end
                  if (CMD_LOAD) pend_q <= CMD_IN;
               end
               ST_S_LO: begin
                  if (!cdck_s2_q) begin
                     rx_q[4*idx_q +: 4] <= dout_s2_q;
                     hock_q  <= 1'b1;
                     wait_q  <= TO_LOAD;
                     state_q <= ST_S_HI;
                  end else begin
                     wait_q <= wait_q - 1'b1;
                  end
               end
               ST_S_HI: begin
                  if (cdck_s2_q) begin
                     hock_q <= 1'b0;
                     wait_q <= TO_LOAD;
                     if (idx_q != 4'd9) begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= ST_S_LO;
                     end else begin
                        idx_q   <= 4'd0;
                        din_q   <= tx_q[3:0];
                        state_q <= ST_C_LO;
                     end
                  end else begin
                     wait_q <= wait_q - 1'b1;
                  end
               end
               ST_C_LO: begin
                  if (!setup_act_q) begin
                     if (!cdck_s2_q) begin
                        setup_act_q <= 1'b1;
                        setup_q     <= SU_LOAD;
                     end else begin
                        wait_q <= wait_q - 1'b1;
                     end
                  end else if (setup_q == '0) begin
                     setup_act_q <= 1'b0;
                     hock_q      <= 1'b1;
                     wait_q      <= TO_LOAD;
                     state_q     <= ST_C_HI;
                  end else begin
                     setup_q <= setup_q - 1'b1;
                  end
               end
               ST_C_HI: begin
                  if (cdck_s2_q) begin
                     if (idx_q != 4'd9) begin
                        idx_q   <= idx_q + 4'd1;
                        din_q   <= nib(tx_q, idx_q + 4'd1);
                        hock_q  <= 1'b0;
                        wait_q  <= TO_LOAD;
                        state_q <= ST_C_LO;
                     end else begin
                        state_q <= ST_DONE;
                     end
                  end else begin
                     wait_q <= wait_q - 1'b1;
                  end
               end
               ST_DONE: begin
                  done_q <= 1'b1;
                  if (cksum(rx_q) == rx_q[39:36]) begin
                     status_q <= rx_q;
                     sv_q     <= 1'b1;
                  end else begin
                     ckerr_q <= 1'b1;
                  end
                  shadow_vld_q <= 1'b0;
                  if (CMD_LOAD)          pend_q <= CMD_IN;
                  else if (shadow_vld_q) pend_q <= shadow_q;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign HOCK         = hock_q;
   assign CDD_DIN      = din_q;
   assign STATUS_OUT   = status_q;
   assign STATUS_VALID = sv_q;
   assign CMD_DONE     = done_q;
   assign CKSUM_ERR    = ckerr_q;
   assign TIMEOUT_ERR  = toerr_q;
   assign BUSY         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cd_host_link.sv
// Bench for cd_host_link: a behavioural CD drive plus a command/status reference model.
module tb_cd_host_link;

   localparam int SETUP = 16;
   localparam int TMO   = 1000;

   logic        clk_sys  = 1'b0;
   logic        nRESET   = 1'b0;
   logic        CDD_nIRQ = 1'b1;
   logic        CDCK     = 1'b1;
   logic [3:0]  CDD_DOUT = 4'd0;
   logic [39:0] CMD_IN   = 40'd0;
   logic        CMD_LOAD = 1'b0;
   logic        HOCK;
   logic [3:0]  CDD_DIN;
   logic [39:0] STATUS_OUT;
   logic        STATUS_VALID, CMD_DONE, CKSUM_ERR, TIMEOUT_ERR, BUSY;

   always #5 clk_sys = ~clk_sys;

   cd_host_link #(.SETUP_CYC(SETUP), .TIMEOUT_CYC(TMO), .GEN_CKSUM(1'b1)) dut (
      .clk_sys(clk_sys), .nRESET(nRESET), .CDD_nIRQ(CDD_nIRQ), .CDCK(CDCK),
      .CDD_DOUT(CDD_DOUT), .HOCK(HOCK), .CDD_DIN(CDD_DIN), .CMD_IN(CMD_IN),
      .CMD_LOAD(CMD_LOAD), .STATUS_OUT(STATUS_OUT), .STATUS_VALID(STATUS_VALID),
      .CMD_DONE(CMD_DONE), .CKSUM_ERR(CKSUM_ERR), .TIMEOUT_ERR(TIMEOUT_ERR), .BUSY(BUSY)
   );

   int errors = 0;
   int checks = 0;
   int n_sv = 0, n_cd = 0, n_ck = 0, n_to = 0, n_hold = 0, n_setup = 0;

   logic [39:0] m_pend = 40'd0, m_shadow = 40'd0, m_status = 40'd0, m_sent = 40'd0;
   bit          m_shvld = 1'b0;

   // Pulse counting and DIN stability, sampled just after each rising edge.
   initial begin
      int         din_age;
      logic       prev_hock;
      logic [3:0] prev_din;
      din_age   = 0;
      prev_hock = 1'b1;
      prev_din  = 4'd0;
      forever begin
         @(posedge clk_sys);
         #1;
         if (!nRESET) begin
            din_age = 0;
         end else begin
            if (STATUS_VALID) n_sv++;
            if (CMD_DONE)     n_cd++;
            if (CKSUM_ERR)    n_ck++;
            if (TIMEOUT_ERR)  n_to++;
            if (prev_hock && HOCK && CDD_DIN !== prev_din) n_hold++;
            if (CDD_DIN !== prev_din) din_age = 0;
            else din_age++;
            if (!prev_hock && HOCK && din_age < SETUP) n_setup++;
         end
         prev_hock = HOCK;
         prev_din  = CDD_DIN;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int nsum9(input logic [39:0] f);
      int s;
      s = 0;
      for (int k = 0; k < 9; k++) s += int'(f[4*k +: 4]);
      return s;
   endfunction

   function automatic logic [39:0] ref_cmd(input logic [39:0] c);
      return {4'(15 - (nsum9(c) % 16)), c[35:0]};
   endfunction

   function automatic bit ref_good(input logic [39:0] f);
      return int'(f[39:36]) == 15 - (nsum9(f) % 16);
   endfunction

   function automatic logic [39:0] rand40();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[39:0];
   endfunction

   task automatic wait_hock(input logic v, output bit ok);
      int n;
      n = 0;
      while (HOCK !== v && n < 400) begin
         @(negedge clk_sys);
         n++;
      end
      ok = (HOCK === v);
      check("hs_wait", 64'(ok), 64'd1);
   endtask

   task automatic load_idle(input logic [39:0] v);
      CMD_IN   = v;
      CMD_LOAD = 1'b1;
      @(negedge clk_sys);
      CMD_LOAD = 1'b0;
      m_pend   = v;
   endtask

   // Drive side of one frame. res: 0 complete, 1 timed out, 2 reset, 3 handshake lost.
   task automatic drive_frame(input logic [39:0] st, input int freeze_at, input int load_at,
                              input logic [39:0] load_val, input int rst_at, input bit hold,
                              output logic [39:0] rx, output int res);
      bit ok;
      int n;
      rx = 40'd0;
      res = 0;
      CDD_nIRQ = 1'b0;
      repeat (4) @(negedge clk_sys);
      if (!hold) CDD_nIRQ = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wait_hock(1'b0, ok);
         if (!ok) begin res = 3; return; end
         CDD_DOUT = st[4*i +: 4];
         repeat (2) @(negedge clk_sys);
         CDCK = 1'b0;
         wait_hock(1'b1, ok);
         if (!ok) begin res = 3; return; end
         if (i == freeze_at) begin
            n = 0;
            while (TIMEOUT_ERR !== 1'b1 && n < 3 * TMO) begin
               @(negedge clk_sys);
               n++;
            end
            checks++;
            assert (n >= TMO - 2 && n <= TMO + 2) else begin
               errors++;
               $error("FAIL to_latency observed=%0d cycles expected=%0d", n, TMO);
            end
            check("to_hock", 64'(HOCK), 64'd1);
            check("to_busy", 64'(BUSY), 64'd0);
            CDCK = 1'b1;
            res = 1;
            return;
         end
         CDCK = 1'b1;
      end
      for (int i = 0; i < 10; i++) begin
         wait_hock(1'b0, ok);
         if (!ok) begin res = 3; return; end
         CDCK = 1'b0;
         if (i == rst_at) begin
            repeat (3) @(negedge clk_sys);
            nRESET = 1'b0;
            @(negedge clk_sys);
            check("rst_hock", 64'(HOCK), 64'd1);
            check("rst_din", 64'(CDD_DIN), 64'd0);
            check("rst_busy", 64'(BUSY), 64'd0);
            nRESET = 1'b1;
            CDCK = 1'b1;
            res = 2;
            return;
         end
         wait_hock(1'b1, ok);
         if (!ok) begin res = 3; return; end
         rx[4*i +: 4] = CDD_DIN;
         if (i == load_at) begin
            CMD_IN   = load_val;
            CMD_LOAD = 1'b1;
            @(negedge clk_sys);
            CMD_LOAD = 1'b0;
         end
         CDCK = 1'b1;
      end
   endtask

   task automatic frame(input string tag, input logic [39:0] st, input int freeze_at,
                        input int load_at, input logic [39:0] load_val, input int rst_at,
                        input bit hold);
      int sv0, cd0, ck0, to0, res;
      logic [39:0] rx;
      bit good;
      sv0 = n_sv; cd0 = n_cd; ck0 = n_ck; to0 = n_to;
      m_sent = ref_cmd(m_pend);
      m_pend = 40'd0;
      drive_frame(st, freeze_at, load_at, load_val, rst_at, hold, rx, res);
      if (load_at >= 0 && res != 2) begin m_shadow = load_val; m_shvld = 1'b1; end
      repeat (8) @(negedge clk_sys);
      case (res)
         0: begin
            good = ref_good(st);
            if (good) m_status = st;
            check({tag, "_cmd"}, 64'(rx), 64'(m_sent));
            check({tag, "_done"}, 64'(n_cd - cd0), 64'd1);
            check({tag, "_sv"}, 64'(n_sv - sv0), good ? 64'd1 : 64'd0);
            check({tag, "_ckerr"}, 64'(n_ck - ck0), good ? 64'd0 : 64'd1);
            check({tag, "_status"}, 64'(STATUS_OUT), 64'(m_status));
            check({tag, "_busy"}, 64'(BUSY), 64'd0);
            if (m_shvld) m_pend = m_shadow;
            m_shvld = 1'b0;
         end
         1: begin
            check({tag, "_to_cnt"}, 64'(n_to - to0), 64'd1);
            check({tag, "_to_sv"}, 64'(n_sv - sv0), 64'd0);
            check({tag, "_to_done"}, 64'(n_cd - cd0), 64'd0);
            m_pend  = m_shvld ? m_shadow : m_sent;
            m_shvld = 1'b0;
         end
         default: begin
            if (res == 3) begin
               nRESET = 1'b0;
               @(negedge clk_sys);
               nRESET = 1'b1;
               CDCK = 1'b1;
            end
            m_pend = 40'd0; m_shadow = 40'd0; m_shvld = 1'b0; m_status = 40'd0;
            check({tag, "_rst_status"}, 64'(STATUS_OUT), 64'd0);
            check({tag, "_rst_done"}, 64'(n_cd - cd0), 64'd0);
         end
      endcase
      if (hold) begin
         cd0 = n_cd;
         repeat (30) @(negedge clk_sys);
         check({tag, "_lvl_busy"}, 64'(BUSY), 64'd0);
         check({tag, "_lvl_done"}, 64'(n_cd - cd0), 64'd0);
      end
      CDD_nIRQ = 1'b1;
      repeat (10) @(negedge clk_sys);
   endtask

   function automatic logic [39:0] good_status(input logic [39:0] b);
      return ref_cmd(b);
   endfunction

   initial begin
      logic [39:0] st;
      repeat (5) @(negedge clk_sys);
      check("rst_hock0", 64'(HOCK), 64'd1);
      check("rst_din0", 64'(CDD_DIN), 64'd0);
      check("rst_status0", 64'(STATUS_OUT), 64'd0);
      check("rst_busy0", 64'(BUSY), 64'd0);
      check("rst_pulses0", 64'({STATUS_VALID, CMD_DONE, CKSUM_ERR, TIMEOUT_ERR}), 64'd0);
      nRESET = 1'b1;
      repeat (10) @(negedge clk_sys);

      load_idle(40'h00_0000_0003);
      frame("basic", 40'h29_8765_4321, -1, -1, 40'd0, -1, 1'b0);
      frame("nop", good_status(rand40()), -1, -1, 40'd0, -1, 1'b0);
      frame("badck", 40'h09_8765_4321, -1, -1, 40'd0, -1, 1'b0);

      load_idle(rand40());
      frame("tmo", good_status(rand40()), 4, -1, 40'd0, -1, 1'b0);
      frame("resend", good_status(rand40()), -1, -1, 40'd0, -1, 1'b0);

      load_idle(rand40());
      frame("shadow", good_status(rand40()), -1, 5, 40'h00_0000_0001, -1, 1'b0);
      frame("shadow2", good_status(rand40()), -1, -1, 40'd0, -1, 1'b0);

      load_idle(rand40());
      frame("rstclo", good_status(rand40()), -1, -1, 40'd0, 3, 1'b0);
      frame("postrst", good_status(rand40()), -1, -1, 40'd0, -1, 1'b0);

      frame("level", good_status(rand40()), -1, -1, 40'd0, -1, 1'b1);

      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(1, 0) == 1) load_idle(rand40());
         st = good_status(rand40());
         if ($urandom_range(3, 0) == 0) st[39:36] = st[39:36] ^ 4'($urandom_range(15, 1));
         frame($sformatf("rnd%0d", r), st, -1,
               ($urandom_range(2, 0) == 0) ? int'($urandom_range(9, 0)) : -1,
               rand40(), -1, 1'b0);
      end

      check("din_hold", 64'(n_hold), 64'd0);
      check("din_setup", 64'(n_setup), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
